prince_sbox_layer_ctrl: RTL
===========================

PRINCE_SBOX_LAYER_CTRL -- requirements
Module: prince_sbox_layer_ctrl

Interface
REQ-001 SHALL have parameter NSHARES, default 3: number of CMS shares per bit.
REQ-002 SHALL have parameter SBOX_LAT, default 1: masked S-box latency in cycles, 1..4.
REQ-003 SHALL have parameter RND_W, default 4: fresh-randomness bits consumed per nibble.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  one-cycle request to process one 64-bit shared state.
REQ-007 inv  in  1  select inverse S-box for this layer (see Configuration).
REQ-008 state_in  in  64*NSHARES  shared state; share s at [64*s +: 64], sampled on accepted start.
REQ-009 rnd_valid  in  1  fresh randomness available.
REQ-010 rnd_data  in  RND_W  fresh randomness.
REQ-011 rnd_ready  out  1  randomness consumed this cycle.
REQ-012 sbox_in  out  4*NSHARES  one shared nibble to external masked S-box; share s at [4*s +: 4].
REQ-013 sbox_rnd  out  RND_W  randomness to S-box, issued with sbox_in.
REQ-014 sbox_inv  out  1  S-box direction select.
REQ-015 sbox_out  in  4*NSHARES  shared S-box result, valid SBOX_LAT cycles after issue.
REQ-016 busy  out  1  layer in progress.
REQ-017 done  out  1  one-cycle pulse, state_out complete.
REQ-018 state_out  out  64*NSHARES  shared result layer, same share layout as state_in.

Function
REQ-019 SHALL implement FSM states IDLE, FEED, DRAIN, DONE; transitions IDLE->FEED on start, FEED->DRAIN after nibble 15 issued, DRAIN->DONE when nibble 15 written, DONE->IDLE unconditionally next cycle.
REQ-020 start SHALL be accepted only in IDLE; start in FEED/DRAIN/DONE SHALL be ignored with no state change.
REQ-021 On accepted start the block SHALL register state_in, clear issue index to 0, set busy=1 next cycle.
REQ-022 In FEED, issue SHALL occur in a cycle iff rnd_valid=1; then rnd_ready=1, sbox_in = nibble idx of every share (nibble i = bits [4i+3:4i]), sbox_rnd = rnd_data, idx increments.
REQ-023 rnd_ready SHALL be 0 in every state except FEED and SHALL equal rnd_valid in FEED (no issue without randomness; stall holds idx).
REQ-024 sbox_in and sbox_rnd SHALL be driven to all-zero in cycles without issue, so no share value is presented unmasked-idle.
REQ-025 An SBOX_LAT-deep valid/index shift register SHALL track issues; when its tail is valid, sbox_out SHALL be written to nibble position of that index in the result register.
REQ-026 Stalls SHALL NOT stall the tracking pipeline; results of issued nibbles SHALL be captured exactly SBOX_LAT cycles after issue regardless of later stalls.
REQ-027 With no stalls, done SHALL assert exactly 1+16+SBOX_LAT cycles after the start cycle (start in cycle 0, first issue cycle 1).
REQ-028 busy SHALL be 1 in FEED and DRAIN, 0 in IDLE and DONE.
REQ-029 state_out SHALL hold the last completed layer from done until the next done; partially written results SHALL not be visible (separate output register loaded in DONE).
REQ-030 Shares SHALL never be combined: no logic SHALL XOR or AND bits of different shares.

Reset
REQ-031 Asserting rst_n=0 SHALL immediately force IDLE, idx=0, pipeline valids=0, busy=0, done=0, rnd_ready=0, sbox_in=0, sbox_rnd=0, sbox_inv=0, state_out=0, including mid-layer; in-flight results SHALL be discarded.
REQ-032 After rst_n release the first start SHALL be accepted in the first clock edge.

Configuration
REQ-033 With macro PRINCE_SBOX_INV_EN defined, inv SHALL be sampled on accepted start and sbox_inv SHALL hold that value through FEED and DRAIN.
REQ-034 Without PRINCE_SBOX_INV_EN, inv SHALL be ignored and sbox_inv SHALL be constant 0.

Verification
REQ-035 Defaults, rnd_valid=1 constant, start with share0=0x0123456789ABCDEF, other shares 0, S-box model = PRINCE S-box -> done at cycle 18, share XOR of state_out = S-layer of input, rnd_ready high 16 cycles.
REQ-036 Same stimulus, rnd_valid low on cycles 3-7 -> done delayed by exactly 5 cycles, same result, idx order 0..15 preserved.
REQ-037 SBOX_LAT=3, random 3-share state -> done at cycle 20, recombined state_out correct, sbox_in zero in non-issue cycles.
REQ-038 rst_n pulsed low at cycle 9 of a layer -> busy=0, state_out=0 immediately; next start completes correctly with no stale nibbles.
REQ-039 start reasserted during FEED -> ignored; exactly one done; PRINCE_SBOX_INV_EN defined with inv=1 -> sbox_inv=1 for whole layer and inverse S-layer result; undefined -> sbox_inv=0.

Source files
------------

// File: rtl/prince_sbox_layer_ctrl_if.sv
// Request / masked-S-box bundle for prince_sbox_layer_ctrl.
// Share s of every shared vector sits at [w*s +: w], where w is 64 (state) or 4 (nibble).
interface prince_sbox_layer_ctrl_if #(
   parameter int unsigned NSHARES = 3,
   parameter int unsigned RND_W   = 4
);
   logic                    start;
   logic                    inv;
   logic [64*NSHARES-1:0]   state_in;
   logic                    rnd_valid;
   logic [RND_W-1:0]        rnd_data;
   logic                    rnd_ready;
   logic [4*NSHARES-1:0]    sbox_in;
   logic [RND_W-1:0]        sbox_rnd;
   logic                    sbox_inv;
   logic [4*NSHARES-1:0]    sbox_out;
   logic                    busy;
   logic                    done;
   logic [64*NSHARES-1:0]   state_out;

   modport master (
      output start, inv, state_in, rnd_valid, rnd_data, sbox_out,
      input  rnd_ready, sbox_in, sbox_rnd, sbox_inv, busy, done, state_out
   );

   modport slave (
      input  start, inv, state_in, rnd_valid, rnd_data, sbox_out,
      output rnd_ready, sbox_in, sbox_rnd, sbox_inv, busy, done, state_out
   );
endinterface

// File: rtl/prince_sbox_layer_ctrl.sv
// Sequences one shared 64-bit PRINCE state nibble-by-nibble through an external masked S-box.
// Optional macro PRINCE_SBOX_INV_EN enables the inverse-layer select (inv sampled on start).
module prince_sbox_layer_ctrl #(
   parameter int unsigned NSHARES  = 3,
   parameter int unsigned SBOX_LAT = 1,
   parameter int unsigned RND_W    = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   prince_sbox_layer_ctrl_if.slave bus
);
   localparam int unsigned SW = 64 * NSHARES;

   typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

   state_t          cur, nxt;
   logic [3:0]      idx;
   logic [SW-1:0]   st_q, res_q, res_nxt, out_q;
   logic            pv   [SBOX_LAT];
   logic [3:0]      pidx [SBOX_LAT];
   logic            issue, accept, tail_wr;
   logic [3:0]      tail_idx;

   assign tail_wr  = pv[SBOX_LAT-1];
   assign tail_idx = pidx[SBOX_LAT-1];

   always_comb begin
      nxt    = cur;
      issue  = 1'b0;
      accept = 1'b0;
      unique case (cur)
         IDLE:  if (bus.start) begin
                   accept = 1'b1;
                   nxt    = FEED;
                end
         FEED:  if (bus.rnd_valid) begin
                   issue = 1'b1;
                   if (idx == 4'hF) nxt = DRAIN;
                end
         DRAIN: if (tail_wr && (tail_idx == 4'hF)) nxt = DONE;
         DONE:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // Non-issue cycles present all-zero shares and randomness to the S-box.
   always_comb begin
      bus.rnd_ready = issue;
      bus.busy      = (cur == FEED) || (cur == DRAIN);
      bus.done      = (cur == DONE);
      bus.state_out = out_q;
      bus.sbox_rnd  = issue ? bus.rnd_data : '0;
      bus.sbox_in   = '0;
      for (int unsigned s = 0; s < NSHARES; s++) begin
         if (issue) bus.sbox_in[4*s +: 4] = st_q[64*s + 4*idx +: 4];
      end
   end

   always_comb begin
      res_nxt = res_q;
      if (tail_wr) begin
         for (int unsigned s = 0; s < NSHARES; s++) begin
            res_nxt[64*s + 4*tail_idx +: 4] = bus.sbox_out[4*s +: 4];
         end
      end
   end

`ifdef PRINCE_SBOX_INV_EN
   logic inv_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      inv_q <= 1'b0;
      else if (accept) inv_q <= bus.inv;
   end

   always_comb bus.sbox_inv = inv_q & bus.busy;
`else
   logic unused_inv;

   always_comb begin
      unused_inv   = bus.inv;
      bus.sbox_inv = 1'b0;
   end
`endif

   // The output register takes the merged result on the edge that writes nibble 15,
   // so state_out is already complete in the cycle done is high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur   <= IDLE;
         idx   <= '0;
         st_q  <= '0;
         res_q <= '0;
         out_q <= '0;
      end else begin
         cur   <= nxt;
         res_q <= res_nxt;
         if (accept) begin
            st_q <= bus.state_in;
            idx  <= '0;
         end else if (issue) begin
            idx <= idx + 4'd1;
         end
         if (nxt == DONE) out_q <= res_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < SBOX_LAT; i++) begin
            pv[i]   <= 1'b0;
            pidx[i] <= '0;
         end
      end else begin
         pv[0]   <= issue;
         pidx[0] <= idx;
         for (int unsigned i = 1; i < SBOX_LAT; i++) begin
            pv[i]   <= pv[i-1];
            pidx[i] <= pidx[i-1];
         end
      end
   end
endmodule
